seg7_capture: RTL and testbench

- Reader for the team's multiplexed 4-digit 7-segment display bus: samples the active-high segment lines a..g and the one-hot digit enables, and recovers the BCD value shown on each digit.
- Sits beside the display driver so self-test logic and the bench can check what is actually being shown.
- Requires a pattern to be stable for a programmable number of cycles before accepting it, which filters multiplex transitions and ghosting.
- Reports per-digit values, a blank flag per digit, sticky illegal-pattern flags, and a frame-complete pulse.

---
 rtl/seg7_capture.sv | 145 ++++++++++++++
 tb/tb_seg7_capture.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Snoops a multiplexed 4-digit 7-segment bus and recovers the BCD value shown on each digit.
// A pattern is accepted once it has been sampled unchanged for STABLE_CYCLES consecutive cycles.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic       d_i,
  input  logic       e_i,
  input  logic       f_i,
  input  logic       g_i,
  input  logic [3:0] an_i,
  input  logic       clr_err_i,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic [3:0] digit3_o,
  output logic [3:0] blank_o,
  output logic [3:0] err_flags_o,
  output logic       seg_err_o,
  output logic       frame_valid_o
);

  localparam logic [CNT_W:0] STABLE_L = (CNT_W+1)'(STABLE_CYCLES);

  logic [10:0]      sample_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   run_len;
  logic             accept, acc_valid;
  logic [3:0]       an_w;
  logic [6:0]       seg_w;
  logic             an_onehot;
  logic [3:0]       dec_val;
  logic             dec_blank, dec_err;
  logic [3:0]       seen_q, seen_d, seen_hit;
  logic             seg_err_q, seg_err_d, frame_valid_q, frame_valid_d;
  logic [3:0]       digit_w [4];

  assign an_w  = sample_q[10:7];
  assign seg_w = sample_q[6:0];

  // run_len is how many consecutive samples (including the current one) equal sample_q
  always_comb begin
    run_len   = (sample_q == prev_q) ? ({1'b0, cnt_q} + 1'b1) : (CNT_W+1)'(1);
    cnt_d     = (run_len > STABLE_L) ? STABLE_L[CNT_W-1:0] : run_len[CNT_W-1:0];
    accept    = (run_len == STABLE_L);
    an_onehot = (an_w != 4'd0) && ((an_w & (an_w - 4'd1)) == 4'd0);
    acc_valid = accept && an_onehot;
  end

  always_comb begin
    dec_val = 4'hE;
    case (seg_w)
      7'h7E: dec_val = 4'd0;
      7'h30: dec_val = 4'd1;
      7'h6D: dec_val = 4'd2;
      7'h79: dec_val = 4'd3;
      7'h33: dec_val = 4'd4;
      7'h5B: dec_val = 4'd5;
      7'h5F: dec_val = 4'd6;
      7'h70: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h7B: dec_val = 4'd9;
      7'h00: dec_val = 4'hF;
      default: dec_val = 4'hE;
    endcase
    dec_blank = (seg_w == 7'h00);
    dec_err   = (dec_val == 4'hE);
  end

  always_comb begin
    seen_hit      = seen_q | an_w;
    seen_d        = seen_q;
    frame_valid_d = 1'b0;
    seg_err_d     = acc_valid && dec_err;
    if (acc_valid) begin
      if (seen_hit == 4'b1111) begin
        frame_valid_d = 1'b1;
        seen_d        = 4'b0000;
      end else begin
        seen_d = seen_hit;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_q      <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      seen_q        <= '0;
      seg_err_q     <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      sample_q      <= {an_i, a_i, b_i, c_i, d_i, e_i, f_i, g_i};
      prev_q        <= sample_q;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      seg_err_q     <= seg_err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] val_q;
    logic       blank_q, err_q;
    logic       hit;

    assign hit = acc_valid && an_w[gi];

    // A new error on this digit wins over a coincident clear
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        val_q   <= 4'hF;
        blank_q <= 1'b1;
        err_q   <= 1'b0;
      end else begin
        if (hit) begin
          val_q   <= dec_val;
          blank_q <= dec_blank;
        end
        if (hit && dec_err)
          err_q <= 1'b1;
        else if (clr_err_i)
          err_q <= 1'b0;
      end
    end

    assign digit_w[gi]     = val_q;
    assign blank_o[gi]     = blank_q;
    assign err_flags_o[gi] = err_q;
  end

  assign digit0_o      = digit_w[0];
  assign digit1_o      = digit_w[1];
  assign digit2_o      = digit_w[2];
  assign digit3_o      = digit_w[3];
  assign seg_err_o     = seg_err_q;
  assign frame_valid_o = frame_valid_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with STABLE_CYCLES=4: qualification timing, decode,
// frame tracking, error flags, glitch restart and mid-qualification reset.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] an;
  logic       clr_err;
  logic [3:0] digit0, digit1, digit2, digit3, blank, err_flags;
  logic       seg_err, frame_valid;

  int checks = 0;
  int errors = 0;
  int se_cnt = 0;
  int fv_cnt = 0;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_i(seg[6]), .b_i(seg[5]), .c_i(seg[4]), .d_i(seg[3]),
    .e_i(seg[2]), .f_i(seg[1]), .g_i(seg[0]),
    .an_i(an), .clr_err_i(clr_err),
    .digit0_o(digit0), .digit1_o(digit1), .digit2_o(digit2), .digit3_o(digit3),
    .blank_o(blank), .err_flags_o(err_flags),
    .seg_err_o(seg_err), .frame_valid_o(frame_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then sample 1 time unit later and tally pulses
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (seg_err === 1'b1) se_cnt++;
      if (frame_valid === 1'b1) fv_cnt++;
    end
  endtask

  task automatic drive(input logic [3:0] an_v, input logic [6:0] seg_v);
    an  = an_v;
    seg = seg_v;
  endtask

  function automatic logic [15:0] digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  initial begin
    logic [3:0]  step_an  [4];
    logic [6:0]  step_seg [4];
    step_an  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    step_seg = '{7'h7E, 7'h30, 7'h7B, 7'h00};

    // Reset with random inputs
    rst = 1'b1;
    clr_err = 1'b0;
    an  = 4'($urandom);
    seg = 7'($urandom);
    @(negedge clk);
    an  = 4'($urandom);
    seg = 7'($urandom);
    tick(2);
    chk("rst_digits", 32'(digits()), 32'hFFFF);
    chk("rst_blank", 32'(blank), 32'hF);
    chk("rst_err", 32'(err_flags), 32'h0);
    chk("rst_pulses", 32'({seg_err, frame_valid}), 32'h0);

    // Qualification timing: digit0 = 5 on edge 5 only
    rst = 1'b0;
    drive(4'b0001, 7'h5B);
    se_cnt = 0; fv_cnt = 0;
    tick(4);
    chk("qual_edge4_digit0", 32'(digit0), 32'hF);
    tick(1);
    chk("qual_edge5_digit0", 32'(digit0), 32'h5);
    chk("qual_edge5_blank", 32'(blank), 32'hE);
    tick(1);
    chk("qual_no_frame", 32'(fv_cnt), 32'd0);

    // Frame: 0,1,9,blank; frame_valid only on the 4th accept
    for (int s = 0; s < 4; s++) begin
      drive(step_an[s], step_seg[s]);
      fv_cnt = 0;
      tick(8);
      chk($sformatf("frame_step%0d_fv", s), 32'(fv_cnt), (s == 3) ? 32'd1 : 32'd0);
    end
    chk("frame_digits", 32'(digits()), 32'hF910);
    chk("frame_blank", 32'(blank), 32'h8);

    // Illegal pattern on digit2 (seen was cleared, so no frame pulse here)
    drive(4'b0100, 7'h7C);
    se_cnt = 0; fv_cnt = 0;
    tick(8);
    chk("illegal_digit2", 32'(digit2), 32'hE);
    chk("illegal_err", 32'(err_flags), 32'h4);
    chk("illegal_seg_err_pulses", 32'(se_cnt), 32'd1);
    chk("illegal_blank", 32'(blank), 32'h8);
    chk("seen_cleared_no_fv", 32'(fv_cnt), 32'd0);

    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err_alone", 32'(err_flags), 32'h0);

    // clr_err on the same edge as a fresh illegal accept: set wins
    drive(4'b0100, 7'h01);
    tick(4);
    chk("pre_set_wins_err", 32'(err_flags), 32'h0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("set_wins_err", 32'(err_flags), 32'h4);
    chk("set_wins_seg_err", 32'(seg_err), 32'h1);

    // Non-one-hot digit enables are ignored
    se_cnt = 0; fv_cnt = 0;
    drive(4'b0011, 7'h7F);
    tick(10);
    drive(4'b0000, 7'h7F);
    tick(6);
    chk("nonhot_digits", 32'(digits()), 32'hFE10);
    chk("nonhot_blank", 32'(blank), 32'h8);
    chk("nonhot_pulses", 32'(se_cnt + fv_cnt), 32'd0);

    // Glitch restarts qualification
    drive(4'b0001, 7'h30);
    tick(3);
    drive(4'b0001, 7'h7F);
    tick(1);
    drive(4'b0001, 7'h30);
    tick(4);
    chk("glitch_edge4_digit0", 32'(digit0), 32'h0);
    tick(1);
    chk("glitch_edge5_digit0", 32'(digit0), 32'h1);

    // Reset mid-qualification, then requalify from scratch
    drive(4'b0010, 7'h6D);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_digit1", 32'(digit1), 32'hF);
    chk("midrst_blank", 32'(blank), 32'hF);
    tick(4);
    chk("requal_edge4_digit1", 32'(digit1), 32'hF);
    tick(1);
    chk("requal_edge5_digit1", 32'(digit1), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
